// File: rtl/oam_dma_pkg.sv
// Shared bus constants and state encoding for the sprite DMA engine.
// Imported by the engine and by anything that decodes its bus ports.
package oam_dma_pkg;

  localparam logic [15:0] DMA_PORT_ADDR = 16'h4014;
  localparam logic [15:0] OAM_PORT_ADDR = 16'h2004;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PEND  = 3'd1,
    S_DUMMY = 3'd2,
    S_ALIGN = 3'd3,
    S_RD    = 3'd4,
    S_WR    = 3'd5,
    S_DONE  = 3'd6
  } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA engine: snoops CPU writes to the DMA port, stalls the CPU at its
// next opcode fetch and copies one 256-byte page to the PPU OAM data port.
module oam_dma
  import oam_dma_pkg::*;
#(
  parameter logic [15:0] DMA_PORT = DMA_PORT_ADDR,
  parameter logic [15:0] OAM_PORT = OAM_PORT_ADDR
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ce,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_d,
  input  logic        cpu_w,
  input  logic        cpu_m0,
  output logic        cpu_ce,
  output logic        busy,
  output logic [15:0] A,
  input  logic [7:0]  I,
  output logic [7:0]  D,
  output logic        R,
  output logic        W
);

  dma_state_t  r_state;
  dma_state_t  w_state_next;
  logic [7:0]  r_page;
  logic [7:0]  w_page_next;
  logic [7:0]  r_idx;
  logic [7:0]  w_idx_next;
  logic        r_halt;
  logic        w_halt_next;
  logic        r_busy;
  logic        w_busy_next;
  logic [15:0] r_a;
  logic [15:0] w_a_next;
  logic [7:0]  r_d;
  logic [7:0]  w_d_next;
  logic        r_r;
  logic        w_r_next;
  logic        r_w;
  logic        w_w_next;
  logic        r_parity;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_page   <= 8'h00;
      r_idx    <= 8'h00;
      r_halt   <= 1'b0;
      r_busy   <= 1'b0;
      r_a      <= 16'h0000;
      r_d      <= 8'h00;
      r_r      <= 1'b0;
      r_w      <= 1'b0;
      r_parity <= 1'b0;
    end else if (ce) begin
      r_state  <= w_state_next;
      r_page   <= w_page_next;
      r_idx    <= w_idx_next;
      r_halt   <= w_halt_next;
      r_busy   <= w_busy_next;
      r_a      <= w_a_next;
      r_d      <= w_d_next;
      r_r      <= w_r_next;
      r_w      <= w_w_next;
      r_parity <= ~r_parity;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_page_next  = r_page;
    w_idx_next   = r_idx;
    w_halt_next  = r_halt;
    w_busy_next  = r_busy;
    w_a_next     = r_a;
    w_d_next     = r_d;
    w_r_next     = 1'b0;
    w_w_next     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cpu_w && (cpu_a == DMA_PORT)) begin
          w_page_next  = cpu_d;
          w_state_next = S_PEND;
        end
      end
      S_PEND: begin
        if (cpu_m0) begin
          w_halt_next  = 1'b1;
          w_busy_next  = 1'b1;
          w_state_next = S_DUMMY;
        end
      end
      S_DUMMY: w_state_next = r_parity ? S_ALIGN : S_RD;
      S_ALIGN: w_state_next = S_RD;
      S_RD: begin
        w_a_next     = {r_page, r_idx};
        w_r_next     = 1'b1;
        w_state_next = S_WR;
      end
      S_WR: begin
        w_a_next = OAM_PORT;
        w_d_next = I;
        w_w_next = 1'b1;
        if (r_idx == 8'hFF) begin
          // Release halt here so the DONE cycle is already the resumed fetch.
          w_halt_next  = 1'b0;
          w_state_next = S_DONE;
        end else begin
          w_idx_next   = r_idx + 8'd1;
          w_state_next = S_RD;
        end
      end
      S_DONE: begin
        w_halt_next  = 1'b0;
        w_busy_next  = 1'b0;
        w_idx_next   = 8'h00;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign cpu_ce = ce & ~r_halt;
  assign busy   = r_busy;
  assign A      = r_a;
  assign D      = r_d;
  assign R      = r_r;
  assign W      = r_w;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: a bus-side memory model plus a negedge monitor
// feeding per-scenario tasks that check strobe counts, addresses and stall length.
module tb_oam_dma;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce = 1'b0;
  logic [15:0] cpu_a = 16'h0000;
  logic [7:0]  cpu_d = 8'h00;
  logic        cpu_w = 1'b0;
  logic        cpu_m0 = 1'b0;
  logic        cpu_ce;
  logic        busy;
  logic [15:0] A;
  logic [7:0]  I;
  logic [7:0]  D;
  logic        R;
  logic        W;

  oam_dma dut (
    .clock  (clock),
    .reset_n(reset_n),
    .ce     (ce),
    .cpu_a  (cpu_a),
    .cpu_d  (cpu_d),
    .cpu_w  (cpu_w),
    .cpu_m0 (cpu_m0),
    .cpu_ce (cpu_ce),
    .busy   (busy),
    .A      (A),
    .I      (I),
    .D      (D),
    .R      (R),
    .W      (W)
  );

  always #20 clock = ~clock;

  function automatic logic [7:0] mem_f(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  assign I = mem_f(A);

  int tests = 0;
  int fails = 0;
  int ce_mode = 0;
  int tick_n = 0;
  logic [7:0] tb_page = 8'h00;
  logic tb_par = 1'b0;

  // Monitor state
  int halt_cnt = 0, r_cnt = 0, w_cnt = 0, rd_bad = 0, wr_bad = 0, ce_bad = 0;
  int ce_idx = 0, halt_start = 0, first_r = 0;
  logic [7:0] mon_ri = 8'h00, mon_wi = 8'h00;
  logic prev_halt = 1'b0;

  always @(posedge clock) begin
    if (!reset_n) tb_par <= 1'b0;
    else if (ce) tb_par <= ~tb_par;
  end

  always @(negedge clock) begin
    if (!ce && cpu_ce) ce_bad <= ce_bad + 1;
    if (reset_n && ce) begin
      if (!cpu_ce && !prev_halt) halt_start <= ce_idx;
      prev_halt <= !cpu_ce;
      if (!cpu_ce) halt_cnt <= halt_cnt + 1;
      if (R) begin
        if (mon_ri == 8'h00) first_r <= ce_idx;
        if (A !== {tb_page, mon_ri}) rd_bad <= rd_bad + 1;
        mon_ri <= mon_ri + 8'd1;
        r_cnt <= r_cnt + 1;
      end
      if (W) begin
        if (A !== 16'h2004 || D !== mem_f({tb_page, mon_wi})) wr_bad <= wr_bad + 1;
        mon_wi <= mon_wi + 8'd1;
        w_cnt <= w_cnt + 1;
      end
      ce_idx <= ce_idx + 1;
    end
    if (!busy) begin
      mon_ri <= 8'h00;
      mon_wi <= 8'h00;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    tick_n++;
    ce = (ce_mode == 0) ? 1'b1 : ((tick_n % 3) == 0);
  endtask

  task automatic ce_cycle();
    tick();
    while (!ce) tick();
  endtask

  task automatic dma_write(input logic [7:0] page, input logic m0);
    tb_page = page;
    cpu_a = 16'h4014; cpu_d = page; cpu_w = 1'b1; cpu_m0 = m0;
    ce_cycle();
    cpu_a = 16'h0000; cpu_d = 8'h00; cpu_w = 1'b0; cpu_m0 = 1'b0;
  endtask

  // Present m0 so the DUMMY cycle sees parity == dummy_par.
  task automatic take_m0(input logic dummy_par);
    while (tb_par == dummy_par) ce_cycle();
    cpu_m0 = 1'b1;
    ce_cycle();
    cpu_m0 = 1'b0;
  endtask

  task automatic wait_idle(output logic ok);
    int n = 0;
    while (busy && n < 5000) begin tick(); n++; end
    ok = !busy;
    while (!ce) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ce = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    tests++; if (busy !== 1'b0 || R !== 1'b0 || W !== 1'b0) begin fails++;
      $display("FAIL reset_strobes: busy=%b R=%b W=%b expected 0 0 0", busy, R, W); end
    tests++; if (A !== 16'h0000 || D !== 8'h00) begin fails++;
      $display("FAIL reset_bus: A=%h D=%h expected 0000 00", A, D); end
    tests++; if (cpu_ce !== 1'b1) begin fails++;
      $display("FAIL reset_cpu_ce: got %b expected 1", cpu_ce); end
    reset_n = 1'b1;
    ce_cycle();
    $display("[TB] reset: busy=%b cpu_ce=%b", busy, cpu_ce);
  endtask

  task automatic check_xfer(input string nm, input int h0, input int r0, input int w0,
                            input int rb0, input int wb0, input int exp_halt, input int exp_gap,
                            input logic ok);
    tests++; if (ok !== 1'b1) begin fails++;
      $display("FAIL %s_timeout: busy stuck high", nm); end
    tests++; if (halt_cnt - h0 != exp_halt) begin fails++;
      $display("FAIL %s_halt: got %0d halted cycles expected %0d", nm, halt_cnt - h0, exp_halt); end
    tests++; if (r_cnt - r0 != 256 || w_cnt - w0 != 256) begin fails++;
      $display("FAIL %s_count: got R=%0d W=%0d expected 256 256", nm, r_cnt - r0, w_cnt - w0); end
    tests++; if (rd_bad - rb0 != 0 || wr_bad - wb0 != 0) begin fails++;
      $display("FAIL %s_data: got %0d bad reads %0d bad writes expected 0 0", nm, rd_bad - rb0, wr_bad - wb0); end
    tests++; if (first_r - halt_start != exp_gap) begin fails++;
      $display("FAIL %s_first_r: got gap %0d expected %0d", nm, first_r - halt_start, exp_gap); end
    $display("[TB] %s: page=%h halted=%0d R=%0d W=%0d gap=%0d", nm, tb_page,
             halt_cnt - h0, r_cnt - r0, w_cnt - w0, first_r - halt_start);
  endtask

  task automatic test_even();
    int h0 = halt_cnt, r0 = r_cnt, w0 = w_cnt, rb0 = rd_bad, wb0 = wr_bad;
    logic ok;
    dma_write(8'h02, 1'b0);
    take_m0(1'b0);
    wait_idle(ok);
    check_xfer("even", h0, r0, w0, rb0, wb0, 513, 2, ok);
  endtask

  task automatic test_odd();
    int h0 = halt_cnt, r0 = r_cnt, w0 = w_cnt, rb0 = rd_bad, wb0 = wr_bad;
    logic ok;
    dma_write(8'h05, 1'b0);
    take_m0(1'b1);
    wait_idle(ok);
    check_xfer("odd", h0, r0, w0, rb0, wb0, 514, 3, ok);
  endtask

  task automatic test_mid_instr();
    int h0 = halt_cnt, r0 = r_cnt, w0 = w_cnt, rb0 = rd_bad, wb0 = wr_bad;
    logic ok;
    dma_write(8'h03, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cpu_a = (i == 1) ? 16'h4014 : 16'h0300 + 16'(i);
      cpu_d = 8'h07; cpu_w = 1'b1;
      ce_cycle();
      tests++; if (busy !== 1'b0 || cpu_ce !== 1'b1 || W !== 1'b0) begin fails++;
        $display("FAIL pend_%0d: busy=%b cpu_ce=%b W=%b expected 0 1 0", i, busy, cpu_ce, W); end
      $display("[TB] pend cycle %0d: cpu write %h busy=%b cpu_ce=%b", i, cpu_a, busy, cpu_ce);
    end
    cpu_a = 16'h0000; cpu_d = 8'h00; cpu_w = 1'b0;
    take_m0(1'b0);
    tests++; if (busy !== 1'b1) begin fails++;
      $display("FAIL pend_halt: busy=%b expected 1 after m0", busy); end
    wait_idle(ok);
    check_xfer("mid_instr", h0, r0, w0, rb0, wb0, 513, 2, ok);
  endtask

  task automatic test_m0_same_cycle();
    int h0 = halt_cnt, r0 = r_cnt, w0 = w_cnt, rb0 = rd_bad, wb0 = wr_bad;
    logic ok;
    dma_write(8'h09, 1'b1);
    tests++; if (busy !== 1'b0 || cpu_ce !== 1'b1) begin fails++;
      $display("FAIL same_m0: busy=%b cpu_ce=%b expected 0 1", busy, cpu_ce); end
    take_m0(1'b1);
    wait_idle(ok);
    check_xfer("same_m0", h0, r0, w0, rb0, wb0, 514, 3, ok);
  endtask

  task automatic test_reset_mid();
    int w0 = w_cnt, n = 0, ws;
    int h0, r0, w1, rb0, wb0;
    logic ok;
    dma_write(8'h04, 1'b0);
    take_m0(1'b0);
    while ((w_cnt - w0) < 100 && n < 2000) begin tick(); n++; end
    tests++; if (w_cnt - w0 != 100) begin fails++;
      $display("FAIL abort_reach: got %0d writes expected 100", w_cnt - w0); end
    reset_n = 1'b0;
    tick();
    tests++; if (busy !== 1'b0 || cpu_ce !== ce || R !== 1'b0 || W !== 1'b0) begin fails++;
      $display("FAIL abort_state: busy=%b cpu_ce=%b R=%b W=%b expected 0 %b 0 0", busy, cpu_ce, R, W, ce); end
    reset_n = 1'b1;
    ws = w_cnt;
    repeat (600) tick();
    while (!ce) tick();
    tests++; if (w_cnt != ws || busy !== 1'b0) begin fails++;
      $display("FAIL abort_quiet: got %0d writes busy=%b expected 0 0", w_cnt - ws, busy); end
    $display("[TB] abort: writes before reset=%0d after=%0d", ws - w0, w_cnt - ws);
    h0 = halt_cnt; r0 = r_cnt; w1 = w_cnt; rb0 = rd_bad; wb0 = wr_bad;
    dma_write(8'h06, 1'b0);
    take_m0(1'b0);
    wait_idle(ok);
    check_xfer("after_abort", h0, r0, w1, rb0, wb0, 513, 2, ok);
  endtask

  task automatic test_ce_throttle();
    int h0, r0, w0, rb0, wb0, cb0;
    logic ok;
    ce_mode = 1;
    while (!ce) tick();
    h0 = halt_cnt; r0 = r_cnt; w0 = w_cnt; rb0 = rd_bad; wb0 = wr_bad; cb0 = ce_bad;
    dma_write(8'h02, 1'b0);
    take_m0(1'b0);
    wait_idle(ok);
    check_xfer("throttle", h0, r0, w0, rb0, wb0, 513, 2, ok);
    tests++; if (ce_bad != cb0) begin fails++;
      $display("FAIL throttle_cpu_ce: got %0d cycles with cpu_ce=1 while ce=0 expected 0", ce_bad - cb0); end
    ce_mode = 0;
    while (!ce) tick();
  endtask

  task automatic test_other_writes();
    logic [15:0] addrs [2];
    int h0 = halt_cnt;
    addrs[0] = 16'h4015;
    addrs[1] = 16'h2014;
    for (int i = 0; i < 2; i++) begin
      cpu_a = addrs[i]; cpu_d = 8'h11; cpu_w = 1'b1;
      ce_cycle();
      cpu_a = 16'h0000; cpu_w = 1'b0; cpu_m0 = 1'b1;
      repeat (4) ce_cycle();
      cpu_m0 = 1'b0;
      tests++; if (busy !== 1'b0 || cpu_ce !== 1'b1) begin fails++;
        $display("FAIL other_%h: busy=%b cpu_ce=%b expected 0 1", addrs[i], busy, cpu_ce); end
      $display("[TB] write %h: busy=%b cpu_ce=%b", addrs[i], busy, cpu_ce);
    end
    tests++; if (halt_cnt != h0) begin fails++;
      $display("FAIL other_halt: got %0d halted cycles expected 0", halt_cnt - h0); end
  endtask

  initial begin
    test_reset();
    test_even();
    test_odd();
    test_mid_instr();
    test_m0_same_cycle();
    test_reset_mid();
    test_ce_throttle();
    test_other_writes();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #(60000 * 40);
    $display("FAIL watchdog: simulation exceeded 60000 cycles");
    $fatal(1);
  end

endmodule
